// File: rtl/ispm_loader.sv
// Byte-stream boot loader: parses SYNC/LEN framed bytes into little-endian words for the ISPM BRAM write port.
// Optional trailing XOR checksum byte is enabled by defining ISPM_LOADER_CHECKSUM_EN.
module ispm_loader #(
  parameter int         DATA      = 32,
  parameter int         ADDR      = 10,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  input  logic            clear,
  output logic            bram_wr,
  output logic [ADDR-1:0] bram_addr,
  output logic [DATA-1:0] bram_din,
  output logic            core_hold,
  output logic            busy,
  output logic            done,
  output logic            error
);
  localparam int BPW = DATA / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BW-1:0] LAST_LANE = BW'(BPW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
`ifdef ISPM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_ERROR
  } state_t;

  state_t          state_reg;
  logic [7:0]      len_lo_reg;
  logic [15:0]     rem_reg;
  logic [ADDR-1:0] word_cnt_reg;
  logic [BW-1:0]   byte_cnt_reg;
  logic [DATA-1:0] word_reg;
  logic            bram_wr_reg;
  logic [ADDR-1:0] bram_addr_reg;
  logic [DATA-1:0] bram_din_reg;
  logic            done_reg;
  logic            core_hold_reg;
`ifdef ISPM_LOADER_CHECKSUM_EN
  logic [7:0]      csum_reg;
`endif

  logic            accept;
  logic [15:0]     len_next;
  logic            len_bad;
  logic [DATA-1:0] word_next;

  assign in_ready  = (state_reg != S_ERROR);
  assign error     = (state_reg == S_ERROR);
  assign busy      = (state_reg != S_IDLE) && (state_reg != S_ERROR);
  assign bram_wr   = bram_wr_reg;
  assign bram_addr = bram_addr_reg;
  assign bram_din  = bram_din_reg;
  assign done      = done_reg;
  assign core_hold = core_hold_reg;

  assign accept   = in_valid && in_ready;
  assign len_next = {in_data, len_lo_reg};
  // Rejecting oversize lengths here is what keeps the word address from ever wrapping.
  assign len_bad  = (len_next == 16'd0) ||
                    ((ADDR < 16) && ({16'd0, len_next} > (32'd1 << ADDR)));

  always_comb begin
    word_next = word_reg;
    word_next[{byte_cnt_reg, 3'b000} +: 8] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      len_lo_reg    <= 8'd0;
      rem_reg       <= 16'd0;
      word_cnt_reg  <= '0;
      byte_cnt_reg  <= '0;
      word_reg      <= '0;
      bram_wr_reg   <= 1'b0;
      bram_addr_reg <= '0;
      bram_din_reg  <= '0;
      done_reg      <= 1'b0;
      core_hold_reg <= 1'b1;
`ifdef ISPM_LOADER_CHECKSUM_EN
      csum_reg      <= 8'd0;
`endif
    end else begin
      bram_wr_reg <= 1'b0;
      done_reg    <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept && in_data == SYNC_BYTE) begin
            state_reg     <= S_LEN0;
            core_hold_reg <= 1'b1;
            word_cnt_reg  <= '0;
            byte_cnt_reg  <= '0;
`ifdef ISPM_LOADER_CHECKSUM_EN
            csum_reg      <= 8'd0;
`endif
          end
        end
        S_LEN0: begin
          if (accept) begin
            len_lo_reg <= in_data;
            state_reg  <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (accept) begin
            if (len_bad) begin
              state_reg <= S_ERROR;
            end else begin
              rem_reg   <= len_next;
              state_reg <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            word_reg <= word_next;
`ifdef ISPM_LOADER_CHECKSUM_EN
            csum_reg <= csum_reg ^ in_data;
`endif
            if (byte_cnt_reg == LAST_LANE) begin
              byte_cnt_reg  <= '0;
              bram_wr_reg   <= 1'b1;
              bram_addr_reg <= word_cnt_reg;
              bram_din_reg  <= word_next;
              word_cnt_reg  <= word_cnt_reg + 1'b1;
              rem_reg       <= rem_reg - 16'd1;
              if (rem_reg == 16'd1) begin
`ifdef ISPM_LOADER_CHECKSUM_EN
                state_reg     <= S_CSUM;
`else
                state_reg     <= S_IDLE;
                done_reg      <= 1'b1;
                core_hold_reg <= 1'b0;
`endif
              end
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
          end
        end
`ifdef ISPM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            if (in_data == csum_reg) begin
              state_reg     <= S_IDLE;
              done_reg      <= 1'b1;
              core_hold_reg <= 1'b0;
            end else begin
              state_reg <= S_ERROR;
            end
          end
        end
`endif
        S_ERROR: begin
          if (clear) state_reg <= S_IDLE;
        end
        default: state_reg <= S_ERROR;
      endcase
    end
  end
endmodule
